// File: rtl/approx_mul_pkg.sv
// Shared constants and elaboration helpers for the approximate multiplier pipe.
// Column heights follow the plain array partial-product layout.
package approx_mul_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    localparam int MIN_WIDTH = 4;

    // Number of partial-product bits a[i]&b[col-i] that land in one column.
    function automatic int col_height(input int width, input int col);
        if (col < 0 || col > 2*width - 2)
            return 0;
        if (col < width)
            return col + 1;
        return 2*width - 1 - col;
    endfunction

    function automatic bit cfg_ok(input int width, input int approx_cols, input int cnt_w);
        return (width >= MIN_WIDTH) && (width % 2 == 0) &&
               (approx_cols >= 0) && (approx_cols <= 2*width - 2) &&
               (cnt_w >= 1);
    endfunction

endpackage

// File: rtl/approx_mul_reduce.sv
// Partial-product generation and reduction to two rows (sum, carry).
// Low columns are OR-compressed in approximate mode with one compensation carry.
module approx_mul_reduce
    import approx_mul_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 7
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               mode,
    output logic [2*WIDTH-1:0] sum,
    output logic [2*WIDTH-1:0] carry
);

    localparam int PW   = 2*WIDTH;
    localparam int CIDX = (APPROX_COLS > 0) ? APPROX_COLS - 1 : 0;
    // A column holding a single bit can never raise the compensation carry.
    localparam bit COMP_EN = (APPROX_COLS > 0) && (col_height(WIDTH, CIDX) >= 2);
    localparam logic [PW-1:0] HI_MASK  = {PW{1'b1}} << APPROX_COLS;
    localparam logic [PW-1:0] COMP_BIT = PW'(1) << APPROX_COLS;

    logic          approx;
    logic          comp;
    int            ones;
    logic [PW-1:0] keep;
    logic [PW-1:0] or_cols;
    logic [PW-1:0] row;
    logic [PW-1:0] part;
    logic [PW-1:0] acc_s;
    logic [PW-1:0] acc_c;
    logic [PW-1:0] s_nxt;
    logic [PW-1:0] c_nxt;

    always_comb begin
        approx  = (mode == MODE_APPROX);
        keep    = approx ? HI_MASK : {PW{1'b1}};
        or_cols = '0;
        ones    = 0;
        row     = '0;
        part    = '0;
        s_nxt   = '0;
        c_nxt   = '0;

        for (int i = 0; i < WIDTH; i++) begin
            row     = {{WIDTH{1'b0}}, (a[i] ? b : {WIDTH{1'b0}})} << i;
            or_cols = or_cols | row;
            if (row[CIDX])
                ones = ones + 1;
        end

        comp = approx && COMP_EN && (ones >= 2);

        // Masked rows are zero below APPROX_COLS, so the CSA chain never
        // disturbs the OR-compressed bits seeded into the sum row.
        acc_s = or_cols & ~keep;
        acc_c = comp ? COMP_BIT : '0;

        for (int i = 0; i < WIDTH; i++) begin
            row   = {{WIDTH{1'b0}}, (a[i] ? b : {WIDTH{1'b0}})} << i;
            part  = row & keep;
            s_nxt = acc_s ^ acc_c ^ part;
            c_nxt = ((acc_s & acc_c) | (acc_s & part) | (acc_c & part)) << 1;
            acc_s = s_nxt;
            acc_c = c_nxt;
        end

        sum   = acc_s;
        carry = acc_c;
    end

endmodule

// File: rtl/approx_mul_pipe.sv
// Two-stage exact/approximate unsigned multiplier with valid/ready on both sides.
// S1 holds the reduced rows, S2 the carry-propagated product; the pipe moves as one.
module approx_mul_pipe
    import approx_mul_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 7,
    parameter int CNT_W       = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               out_mode,
    output logic [CNT_W-1:0]   approx_cnt
);

    localparam int PW = 2*WIDTH;

    if (!cfg_ok(WIDTH, APPROX_COLS, CNT_W)) begin : g_cfg_err
        $error("approx_mul_pipe: illegal WIDTH/APPROX_COLS/CNT_W combination");
    end

    logic          stall;
    logic          advance;
    logic          consume;
    logic [PW-1:0] red_sum;
    logic [PW-1:0] red_carry;
    logic          s1_valid;
    logic          s1_mode;
    logic [PW-1:0] s1_sum;
    logic [PW-1:0] s1_carry;

    approx_mul_reduce #(
        .WIDTH      (WIDTH),
        .APPROX_COLS(APPROX_COLS)
    ) u_reduce (
        .a    (in_a),
        .b    (in_b),
        .mode (in_mode),
        .sum  (red_sum),
        .carry(red_carry)
    );

    assign stall    = out_valid & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = ~stall;
    assign consume  = out_valid & out_ready;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s1_valid    <= 1'b0;
            s1_mode     <= MODE_EXACT;
            s1_sum      <= '0;
            s1_carry    <= '0;
            out_valid   <= 1'b0;
            out_mode    <= MODE_EXACT;
            out_product <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (in_valid) begin
                s1_mode  <= in_mode;
                s1_sum   <= red_sum;
                s1_carry <= red_carry;
            end
            if (s1_valid) begin
                out_mode    <= s1_mode;
                out_product <= s1_sum + s1_carry;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N)
            approx_cnt <= '0;
        else if (consume && out_mode == MODE_APPROX && approx_cnt != {CNT_W{1'b1}})
            approx_cnt <= approx_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Directed bench for approx_mul_pipe: a K=7 instance and a K=0, CNT_W=4 instance
// share one stimulus stream; a short randomized scoreboard pass closes it out.
module tb_approx_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_mode;
    logic        out_ready;

    logic        in_ready,  in_ready2;
    logic        out_valid, out_valid2;
    logic [15:0] out_product, out_product2;
    logic        out_mode,  out_mode2;
    logic [15:0] approx_cnt;
    logic [3:0]  approx_cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [16:0] q1[$];
    logic [16:0] q2[$];

    always #5 clk = ~clk;

    approx_mul_pipe #(.WIDTH(8), .APPROX_COLS(7), .CNT_W(16)) dut (
        .CLK(clk), .RST_N(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_mode(out_mode),
        .approx_cnt(approx_cnt)
    );

    approx_mul_pipe #(.WIDTH(8), .APPROX_COLS(0), .CNT_W(4)) dut2 (
        .CLK(clk), .RST_N(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_product(out_product2), .out_mode(out_mode2),
        .approx_cnt(approx_cnt2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Column model: counts ones per column, ORs the low K columns, sums the rest.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic m, input int k);
        int          cnt[16];
        logic [31:0] r;
        for (int c = 0; c < 16; c++) cnt[c] = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (a[i] && b[j]) cnt[i+j]++;
        r = 32'd0;
        if (!m || k == 0) begin
            for (int c = 0; c < 16; c++) r = r + (32'(cnt[c]) << c);
        end else begin
            for (int c = 0; c < 16; c++) begin
                if (c < k) begin
                    if (cnt[c] > 0) r = r | (32'd1 << c);
                end else begin
                    r = r + (32'(cnt[c]) << c);
                end
            end
            if (cnt[k-1] >= 2) r = r + (32'd1 << k);
        end
        return r[15:0];
    endfunction

    task automatic run_beat(input logic [7:0] a, input logic [7:0] b, input logic m,
                            input logic [15:0] e1, input logic [15:0] e2, input string tag);
        in_a = a; in_b = b; in_mode = m; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_not_yet"}, out_valid, 0);
        tick();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_prod"}, out_product, e1);
        check({tag, "_mode"}, out_mode, m);
        check({tag, "_prod_k0"}, out_product2, e2);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_product", out_product, 0);
        check("rst_out_mode", out_mode, 0);
        check("rst_approx_cnt", approx_cnt, 0);
        check("rst_in_ready", in_ready, 1);

        // Exact and approximate single beats; dut2 (K=0) always returns a*b.
        run_beat(8'hFF, 8'hFF, 1'b0, 16'd65025, 16'd65025, "exact_ff");
        check("cnt_after_exact", approx_cnt, 0);
        run_beat(8'h0F, 8'h0F, 1'b1, 16'd127, 16'd225, "approx_0f");
        check("cnt_after_approx", approx_cnt, 1);
        check("cnt_k0_after_approx", approx_cnt2, 1);
        run_beat(8'h03, 8'h03, 1'b1, 16'd7, 16'd9, "approx_03");
        run_beat(8'h80, 8'hFF, 1'b1, 16'd32640, 16'd32640, "approx_hi_cols");
        // Column 6 holds seven ones: low 127, compensation 128, upper columns 64256.
        run_beat(8'hFF, 8'hFF, 1'b1, 16'd64511, 16'd65025, "approx_comp");
        check("cnt_four", approx_cnt, 4);

        // Backpressure: fill the pipe with out_ready low, then release.
        out_ready = 1'b0;
        in_a = 8'd3; in_b = 8'd5; in_mode = 1'b0; in_valid = 1'b1;
        tick();
        in_a = 8'd4; in_b = 8'd6;
        tick();
        in_a = 8'd7; in_b = 8'd9;
        #1;
        check("bp_in_ready_low", in_ready, 0);
        for (int c = 0; c < 3; c++) begin
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_prod", out_product, 15);
            tick();
        end
        check("bp_hold_prod_last", out_product, 15);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_back", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_second", out_product, 24);
        check("bp_second_valid", out_valid, 1);
        tick();
        check("bp_third", out_product, 63);
        check("bp_third_valid", out_valid, 1);
        tick();
        check("bp_drained", out_valid, 0);

        // Reset with two beats in flight.
        in_a = 8'd10; in_b = 8'd10; in_mode = 1'b1; in_valid = 1'b1;
        tick();
        in_a = 8'd20; in_b = 8'd20;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_prod", out_product, 0);
        check("mid_rst_cnt", approx_cnt, 0);
        check("mid_rst_in_ready", in_ready, 1);
        tick();
        check("mid_rst_flushed", out_valid, 0);
        run_beat(8'd6, 8'd7, 1'b0, 16'd42, 16'd42, "post_rst");

        // Twenty approximate results back to back: dut2 saturates at 15.
        in_mode = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_a = 8'(i + 1); in_b = 8'(i + 3);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("cnt_twenty", approx_cnt, 20);
        check("cnt_saturated", approx_cnt2, 15);
        check("cnt_drained", out_valid, 0);

        // Random modes, operands and backpressure against the column model.
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_mode   = 1'($urandom);
            #1;
            if (out_valid && out_ready) begin
                if (q1.size() == 0) check("rnd_unexpected", 1, 0);
                else check("rnd_k7", {out_mode, out_product}, q1.pop_front());
            end
            if (out_valid2 && out_ready) begin
                if (q2.size() == 0) check("rnd_unexpected_k0", 1, 0);
                else check("rnd_k0", {out_mode2, out_product2}, q2.pop_front());
            end
            if (in_valid && in_ready)
                q1.push_back({in_mode, model(in_a, in_b, in_mode, 7)});
            if (in_valid && in_ready2)
                q2.push_back({in_mode, model(in_a, in_b, in_mode, 0)});
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            #1;
            if (out_valid) begin
                if (q1.size() == 0) check("drain_unexpected", 1, 0);
                else check("drain_k7", {out_mode, out_product}, q1.pop_front());
            end
            if (out_valid2) begin
                if (q2.size() == 0) check("drain_unexpected_k0", 1, 0);
                else check("drain_k0", {out_mode2, out_product2}, q2.pop_front());
            end
            tick();
        end
        check("rnd_none_lost", q1.size(), 0);
        check("rnd_none_lost_k0", q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
